// File: rtl/fir_mac_if.sv
// rtl/fir_mac_if.sv - control, memory-read and result bundle of the FIR MAC engine
//
// Purpose: groups the run control, the coefficient/sample memory read port and
// the per-channel results so the engine and its environment share one port.
// Signals:
//   start     run request, sampled only while the engine is idle
//   abort     synchronous abort of a run in progress
//   rd_en     memory read strobe for tap_addr/ch_idx
//   tap_addr  tap index for coefficient ROM and sample buffer
//   ch_idx    channel being filtered, selects the sample buffer bank
//   cff_in    coefficient, valid one cycle after rd_en
//   smpl_in   history sample, valid one cycle after rd_en
//   smpl_out  results, channel c at [c*DATA_W +: DATA_W]
//   busy      engine not idle
//   done      one-cycle pulse once every channel of the run is stored
// Modports: slave = engine side, master = environment side.
interface fir_mac_if #(
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 16,
  parameter int NUM_COEFF = 1021,
  parameter int NUM_CH    = 2
);
  localparam int TAP_W = $clog2(NUM_COEFF);
  localparam int CH_W  = $clog2(NUM_CH) + 1;

  logic                     start;
  logic                     abort;
  logic                     rd_en;
  logic [TAP_W-1:0]         tap_addr;
  logic [CH_W-1:0]          ch_idx;
  logic [COEFF_W-1:0]       cff_in;
  logic [DATA_W-1:0]        smpl_in;
  logic [NUM_CH*DATA_W-1:0] smpl_out;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, abort, cff_in, smpl_in,
    output rd_en, tap_addr, ch_idx, smpl_out, busy, done
  );

  modport master (
    output start, abort, cff_in, smpl_in,
    input  rd_en, tap_addr, ch_idx, smpl_out, busy, done
  );
endinterface

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - time-multiplexed multi-channel FIR multiply-accumulate engine
//
// Purpose: one start filters NUM_CH channels back to back, NUM_COEFF taps each,
// reading coefficients and history samples from sync-read memories (1-cycle
// latency), then rounds, saturates and registers one result per channel and
// pulses done.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    fir_mac_if.slave: start/abort in, rd_en/tap_addr/ch_idx out,
//          cff_in/smpl_in in, smpl_out/busy/done out
module fir_mac_engine #(
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 16,
  parameter int NUM_COEFF = 1021,
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = COEFF_W - 1
) (
  input  logic     clk,
  input  logic     rst_n,
  fir_mac_if.slave bus
);
  localparam int TAP_W  = $clog2(NUM_COEFF);
  localparam int CH_W   = $clog2(NUM_CH) + 1;
  localparam int PROD_W = DATA_W + COEFF_W;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_COEFF - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  // Rounding and saturation work one bit wider than the accumulator so the
  // half-LSB add can never wrap.
  localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, STORE, DONE} state_t;

  state_t state, state_nxt;

  logic                     rd_en, busy, done;
  logic                     rd_vld;
  logic [TAP_W-1:0]         tap_addr;
  logic [CH_W-1:0]          ch_idx;
  logic signed [ACC_W-1:0]  acc;
  logic [NUM_CH*DATA_W-1:0] lanes;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    rnd_sum, rnd_shr;
  logic [DATA_W-1:0]        sat_val;
  logic                     abort_run;

  assign abort_run = bus.abort && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (bus.start) state_nxt = MAC;
      MAC: begin
        rd_en = 1'b1;
        if (tap_addr == LAST_TAP) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = STORE;
      STORE: state_nxt = (ch_idx == LAST_CH) ? DONE : MAC;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort outranks every transition, including STORE->DONE.
    if (abort_run) state_nxt = IDLE;
  end

  always_comb begin
    prod    = $signed(bus.cff_in) * $signed(bus.smpl_in);
    rnd_sum = {acc[ACC_W-1], acc} + HALF;
    rnd_shr = rnd_sum >>> OUT_SHIFT;
    if (rnd_shr > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (rnd_shr < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = rnd_shr[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld   <= 1'b0;
      tap_addr <= '0;
      ch_idx   <= '0;
      acc      <= '0;
      lanes    <= '0;
    end else begin
      // Memory data lags rd_en by one cycle, so the product of the last tap
      // lands during DRAIN.
      rd_vld <= rd_en;
      if (rd_vld)
        acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

      if (abort_run) begin
        tap_addr <= '0;
        ch_idx   <= '0;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            tap_addr <= '0;
            ch_idx   <= '0;
            acc      <= '0;
          end
          MAC: if (tap_addr != LAST_TAP) tap_addr <= tap_addr + 1'b1;
          STORE: begin
            for (int c = 0; c < NUM_CH; c++)
              if (ch_idx == CH_W'(c)) lanes[c*DATA_W +: DATA_W] <= sat_val;
            if (ch_idx != LAST_CH) begin
              ch_idx   <= ch_idx + 1'b1;
              tap_addr <= '0;
              acc      <= '0;
            end
          end
          DONE: begin
            tap_addr <= '0;
            ch_idx   <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rd_en    = rd_en;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.tap_addr = tap_addr;
  assign bus.ch_idx   = ch_idx;
  assign bus.smpl_out = lanes;
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - scoreboard bench for fir_mac_engine (4 taps, 2 channels)
//
// Purpose: directed runs with hand-computed lane results pushed into a queue;
// a monitor pops and compares on every done pulse, including run latency.
// Ports: none (top-level bench).
module tb_fir_mac_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_mac_if #(.DATA_W(16), .COEFF_W(16), .NUM_COEFF(4), .NUM_CH(2)) bus ();

  fir_mac_engine #(.NUM_COEFF(4), .NUM_CH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Coefficient ROM shared by both channels; sample buffer has one bank per channel.
  logic [15:0] cff_mem [0:3];
  logic [15:0] smpl_mem [0:1][0:3];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.cff_in  <= cff_mem[bus.tap_addr];
      bus.smpl_in <= smpl_mem[bus.ch_idx[0]][bus.tap_addr];
    end
  end

  typedef struct {
    string       name;
    logic [31:0] lanes;
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_lanes"}, bus.smpl_out, e.lanes);
        chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'd13);
      end
    end
  end

  task automatic load(input logic [15:0] c0, input logic [15:0] c_rest,
                      input logic [15:0] s0, input logic [15:0] s1);
    cff_mem[0] = c0;
    for (int i = 1; i < 4; i++) cff_mem[i] = c_rest;
    for (int i = 0; i < 4; i++) begin
      smpl_mem[0][i] = s0;
      smpl_mem[1][i] = s1;
    end
  endtask

  // Cycle k is the k-th cycle after the one in which start is sampled.
  task automatic run(input string nm, input logic [31:0] lanes,
                     input bit trace, input bit extra_start);
    bit exp_rd;
    @(negedge clk);
    bus.start = 1'b1;
    sb.push_back('{nm, lanes, cyc});
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      bus.start = extra_start && (k == 3);
      if (trace) begin
        exp_rd = (k >= 1 && k <= 4) || (k >= 7 && k <= 10);
        chk($sformatf("%s_rd_en_c%0d", nm, k), 32'(bus.rd_en), 32'(exp_rd));
        chk($sformatf("%s_busy_c%0d", nm, k), 32'(bus.busy), 32'd1);
        if (exp_rd) begin
          chk($sformatf("%s_tap_c%0d", nm, k), 32'(bus.tap_addr),
              (k <= 4) ? 32'(k - 1) : 32'(k - 7));
          chk($sformatf("%s_ch_c%0d", nm, k), 32'(bus.ch_idx),
              (k <= 4) ? 32'd0 : 32'd1);
        end
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_tap"}, 32'(bus.tap_addr), 32'd0);
    chk({nm, "_ch"}, 32'(bus.ch_idx), 32'd0);
    chk({nm, "_lanes"}, bus.smpl_out, 32'd0);
  endtask

  int saved_done;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    load(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    load(16'h4000, 16'h4000, 16'h2000, 16'h2000);
    run("basic", 32'h4000_4000, 1'b1, 1'b0);

    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000);
    run("saturate", 32'h8000_7FFF, 1'b0, 1'b0);

    load(16'h0001, 16'h0000, 16'h4000, 16'h3FFF);
    run("round", 32'h0000_0001, 1'b0, 1'b0);

    // A second start in the middle of MAC must not queue another run.
    load(16'h4000, 16'h4000, 16'h2000, 16'h2000);
    saved_done = done_cnt;
    run("start_busy", 32'h4000_4000, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("start_busy_done_count", 32'(done_cnt - saved_done), 32'd1);

    // Abort in channel 1 MAC: lane0 takes the new value, lane1 keeps 0x4000.
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000);
    saved_done = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 8) bus.abort = 1'b1;
    end
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_lanes", bus.smpl_out, 32'h4000_7FFF);
    chk("abort_no_done", 32'(done_cnt - saved_done), 32'd0);

    // Reset during channel 0 MAC, then a clean run.
    load(16'h0001, 16'h0000, 16'h4000, 16'h3FFF);
    saved_done = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_reset_no_done", 32'(done_cnt - saved_done), 32'd0);
    run("after_reset", 32'h0000_0001, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
